// File: rtl/conv3x3_param_engine.sv
// 3x3 convolution engine: raster-scans the image, one tap fetch per cycle, nine taps per pixel.
// Build option: define CONV_RELU_EN to clamp negative results to zero before the result write.
module conv3x3_param_engine #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = 20,
  parameter int FRAC   = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              finish,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [1:0]        dbg_state
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = 2 * DATA_W + 4;
  localparam int CW = ADDR_W + 2;

  localparam logic [ADDR_W-1:0]    X_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0]    Y_LAST = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0]    W_A    = ADDR_W'(IMG_W);
  localparam logic signed [CW-1:0] W_S    = CW'(IMG_W);
  localparam logic signed [CW-1:0] H_S    = CW'(IMG_H);
  localparam logic signed [CW-1:0] ONE_C  = CW'(1);

  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (FRAC - 1);
  localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (DATA_W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
  localparam logic [DATA_W-1:0]    DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]    DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] x_q, x_d, y_q, y_d, pix_q, pix_d;

  logic signed [DATA_W-1:0] kern_q [10];
  logic signed [DATA_W-1:0] kern_d [10];

  // Stage 1: describes the tap whose ROM data is on idata this cycle.
  logic              v1_q, v1_d;
  logic              inb1_q, inb1_d;
  logic [3:0]        tap1_q, tap1_d;
  logic [ADDR_W-1:0] pix1_q, pix1_d;
  logic              last1_q, last1_d;

  logic signed [AW-1:0] acc_q, acc_d;

  logic              cwr_q, cwr_d;
  logic              finish_q, finish_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;

  logic                     last_pix;
  logic signed [CW-1:0]     tx, ty;
  logic                     in_b;
  logic [3:0]               tap_idx;
  logic [ADDR_W-1:0]        lin_addr;
  logic signed [DATA_W-1:0] pix_s, w_sel;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     acc_init, base, sum, shr;
  logic [DATA_W-1:0]        sat_v, res_v;

  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  // Tap geometry for the tap issued this cycle.
  always_comb begin
    tx       = $signed({2'b00, x_q}) + $signed({{(CW-2){1'b0}}, col_q}) - ONE_C;
    ty       = $signed({2'b00, y_q}) + $signed({{(CW-2){1'b0}}, row_q}) - ONE_C;
    in_b     = !tx[CW-1] && (tx < W_S) && !ty[CW-1] && (ty < H_S);
    tap_idx  = {2'b00, row_q} * 4'd3 + {2'b00, col_q};
    lin_addr = ty[ADDR_W-1:0] * W_A + tx[ADDR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          x_d     = '0;
          y_d     = '0;
          pix_d   = '0;
        end
      end
      S_RUN: begin
        if (col_q == 2'd2) begin
          col_d = '0;
          if (row_q == 2'd2) begin
            row_d = '0;
            if (last_pix) begin
              state_d = S_DRAIN;
              x_d     = '0;
              y_d     = '0;
              pix_d   = '0;
            end else begin
              pix_d = pix_q + ADDR_W'(1);
              if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + ADDR_W'(1);
              end else begin
                x_d = x_q + ADDR_W'(1);
              end
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (finish_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Kernel is writable only while idle, so a frame always sees one kernel.
  always_comb begin
    kern_d = kern_q;
    if (cfg_we && (state_q == S_IDLE) && (cfg_addr <= 4'd9)) begin
      kern_d[cfg_addr] = cfg_wdata;
    end
  end

  always_comb begin
    v1_d    = (state_q == S_RUN);
    inb1_d  = in_b;
    tap1_d  = tap_idx;
    pix1_d  = pix_q;
    last1_d = last_pix;
  end

  always_comb begin
    pix_s    = $signed(idata);
    w_sel    = kern_q[tap1_q];
    prod     = inb1_q ? (PW'(pix_s) * PW'(w_sel)) : '0;
    acc_init = (AW'(kern_q[9]) <<< FRAC) + HALF;
    base     = (tap1_q == 4'd0) ? acc_init : acc_q;
    sum      = base + AW'(prod);
    shr      = sum >>> FRAC;
    if (shr > MAXV)      sat_v = DMAX;
    else if (shr < MINV) sat_v = DMIN;
    else                 sat_v = shr[DATA_W-1:0];
`ifdef CONV_RELU_EN
    res_v = sat_v[DATA_W-1] ? '0 : sat_v;
`else
    res_v = sat_v;
`endif
    acc_d    = v1_q ? sum : acc_q;
    cwr_d    = v1_q && (tap1_q == 4'd8);
    finish_d = v1_q && (tap1_q == 4'd8) && last1_q;
    caddr_d  = cwr_d ? pix1_q : caddr_q;
    cdata_d  = cwr_d ? res_v : cdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= '0;
      kern_q   <= '{default: '0};
      v1_q     <= 1'b0;
      inb1_q   <= 1'b0;
      tap1_q   <= '0;
      pix1_q   <= '0;
      last1_q  <= 1'b0;
      acc_q    <= '0;
      cwr_q    <= 1'b0;
      finish_q <= 1'b0;
      caddr_q  <= '0;
      cdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_q    <= pix_d;
      kern_q   <= kern_d;
      v1_q     <= v1_d;
      inb1_q   <= inb1_d;
      tap1_q   <= tap1_d;
      pix1_q   <= pix1_d;
      last1_q  <= last1_d;
      acc_q    <= acc_d;
      cwr_q    <= cwr_d;
      finish_q <= finish_d;
      caddr_q  <= caddr_d;
      cdata_q  <= cdata_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign iaddr     = ((state_q == S_RUN) && in_b) ? lin_addr : '0;
  assign cwr       = cwr_q;
  assign finish    = finish_q;
  assign caddr_wr  = caddr_q;
  assign cdata_wr  = cdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv3x3_param_engine.sv
// Bench for conv3x3_param_engine: ROM model, arithmetic reference, expected-queue scoreboard.
module tb_conv3x3_param_engine;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 20;
  localparam int FR = 16;
  localparam int AW = 5;
  localparam int N  = W * H;
  localparam int EW = 32 + AW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, finish;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata = '0;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [1:0]    dbg_state;

  conv3x3_param_engine #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .FRAC(FR), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .finish(finish),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] img [N];
  longint        km [10];
  logic [EW-1:0] exp_q [$];
  int checks = 0, failures = 0;
  int ncyc = 0, c0_n = 0;
  bit frame_on = 1'b0;

  always @(posedge clk) idata <= img[iaddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Reference: plain fixed-point arithmetic over the padded 3x3 window.
  task automatic model_frame();
    longint acc, r, lim;
    int xx, yy;
    logic [EW-1:0] e;
    lim = longint'(1) <<< (DW - 1);
    for (int p = 0; p < N; p++) begin
      acc = (km[9] <<< FR) + (longint'(1) <<< (FR - 1));
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          xx = p % W + dx;
          yy = p / W + dy;
          if (xx >= 0 && xx < W && yy >= 0 && yy < H)
            acc += km[(dy + 1) * 3 + dx + 1] * longint'($signed(img[yy * W + xx]));
        end
      end
      r = acc >>> FR;
      if (r > lim - 1) r = lim - 1;
      if (r < -lim) r = -lim;
`ifdef CONV_RELU_EN
      if (r < 0) r = 0;
`endif
      e = {32'(9 * p + 10), AW'(p), DW'(r)};
      exp_q.push_back(e);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (a <= 4'd9) km[a] = longint'($signed(d));
  endtask

  task automatic load_center(input logic [DW-1:0] w4, input logic [DW-1:0] b);
    for (int i = 0; i < 9; i++) cfg_write(4'(i), (i == 4) ? w4 : '0);
    cfg_write(4'd9, b);
  endtask

  task automatic issue_start(input bit co_we, input logic [3:0] co_a, input logic [DW-1:0] co_d);
    @(negedge clk);
    if (co_we) begin
      cfg_we = 1'b1; cfg_addr = co_a; cfg_wdata = co_d;
      if (co_a <= 4'd9) km[co_a] = longint'($signed(co_d));
    end
    model_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_we = 1'b0;
    c0_n = ncyc + 1;
    frame_on = 1'b1;
  endtask

  task automatic run_frame(input bit poke, input bit co_we, input logic [3:0] co_a,
                           input logic [DW-1:0] co_d);
    issue_start(co_we, co_a, co_d);
    if (poke) begin
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        cfg_we = 1'($urandom_range(0, 1));
        cfg_addr = 4'($urandom_range(0, 15));
        cfg_wdata = DW'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      cfg_we = 1'b0;
    end
    for (int i = 0; i < 9 * N + 40 && (frame_on || exp_q.size() != 0); i++) @(negedge clk);
    if (frame_on || exp_q.size() != 0) begin
      chk("frame_done_pending", 64'(exp_q.size()) + 64'(frame_on), 64'd0);
      exp_q.delete();
      frame_on = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_cwr"}, 64'(cwr), 64'd0);
    chk({tag, "_finish"}, 64'(finish), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_iaddr"}, 64'(iaddr), 64'd0);
    chk({tag, "_caddr"}, 64'(caddr_wr), 64'd0);
    chk({tag, "_cdata"}, 64'(cdata_wr), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // Monitor: every write must match the head of the expected queue, at its cycle.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int rel;
    ncyc = ncyc + 1;
    rel = ncyc - c0_n;
    if (cwr) begin
      if (exp_q.size() == 0) begin
        chk("spurious_cwr", 64'(cwr), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("caddr_wr", 64'(caddr_wr), 64'(e[DW +: AW]));
        chk("cdata_wr", 64'(cdata_wr), 64'(e[DW-1:0]));
        chk("write_cycle", 64'(rel), 64'(e[EW-1 -: 32]));
        chk("finish_on_write", 64'(finish), 64'(e[DW +: AW] == AW'(N - 1)));
      end
    end else begin
      chk("finish_idle", 64'(finish), 64'd0);
    end
    if (frame_on) begin
      if (rel == 0) chk("busy_first_fetch", 64'(busy), 64'd1);
      if (rel == 9 * N + 1) chk("busy_last_write", 64'(busy), 64'd1);
      if (rel == 9 * N + 2) begin
        chk("busy_drop", 64'(busy), 64'd0);
        frame_on = 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 10; i++) km[i] = 0;
    for (int i = 0; i < N; i++) img[i] = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Identity kernel
    for (int i = 0; i < N; i++) img[i] = DW'(i * 32'h100);
    load_center(20'h10000, 20'h0);
    run_frame(1'b0, 1'b0, 4'd0, '0);

    // Box sum on a flat image (interior saturates at DATA_W)
    for (int i = 0; i < N; i++) img[i] = 20'h10000;
    for (int i = 0; i < 9; i++) cfg_write(4'(i), 20'h10000);
    run_frame(1'b0, 1'b0, 4'd0, '0);

    // Negative weight, without and with a +0.5 bias
    for (int i = 0; i < N; i++) img[i] = 20'h20000;
    load_center(20'hF0000, 20'h0);
    run_frame(1'b0, 1'b0, 4'd0, '0);
    cfg_write(4'd9, 20'h08000);
    run_frame(1'b0, 1'b0, 4'd0, '0);

    // Saturation at the positive rail
    for (int i = 0; i < N; i++) img[i] = 20'h7FFFF;
    load_center(20'h7FFFF, 20'h0);
    run_frame(1'b0, 1'b0, 4'd0, '0);

    // Half-LSB rounding with 0.5 weight on small odd/even pixels
    for (int i = 0; i < N; i++) img[i] = DW'($signed(32'(i % 7) - 3));
    load_center(20'h08000, 20'h0);
    run_frame(1'b0, 1'b0, 4'd0, '0);

    // Random kernels and images: full-range then small-range
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++)
        img[i] = (f < 2) ? DW'($urandom) : DW'($urandom_range(0, 20'h3FFFF) - 20'h20000);
      for (int i = 0; i < 10; i++)
        cfg_write(4'(i), (f < 2) ? DW'($urandom) : DW'($urandom_range(0, 20'h1FFFF) - 20'h10000));
      run_frame(1'b0, 1'b0, 4'd0, '0);
    end

    // Config write coincident with start, ignored address, then busy-time pokes
    cfg_write(4'd12, 20'h12345);
    run_frame(1'b0, 1'b1, 4'd9, DW'($urandom_range(0, 20'h3FFFF) - 20'h20000));
    run_frame(1'b1, 1'b0, 4'd0, '0);

    // Reset during pixel 5 aborts the frame and clears the kernel
    issue_start(1'b0, 4'd0, '0);
    repeat (56) @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    frame_on = 1'b0;
    for (int i = 0; i < 10; i++) km[i] = 0;
    #1;
    check_zero_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (60) @(negedge clk);
    run_frame(1'b0, 1'b0, 4'd0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", ncyc);
    $fatal(1, "timeout");
  end

endmodule
